// File: rtl/count_seq_checker.sv
// ============================================================================
// Module      : count_seq_checker
// Description : Receive-side checker for a free-running counter; confirms
//               +1 steps, declares lock and keeps error/wrap statistics.
//               Define COUNT_CHECK_RELOCK_EN to re-acquire after a break
//               instead of latching into FAULT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             en,
    input  logic [WIDTH-1:0] q,
    output logic             locked,
    output logic             err,
    output logic [7:0]       err_cnt,
    output logic [7:0]       wrap_cnt,
    output logic [WIDTH-1:0] expected
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] C_ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_ONES     = '1;
    localparam logic [3:0]       C_LOCK_CNT = 4'(LOCK_CNT);

    state_t           r_state;
    logic [WIDTH-1:0] r_prev;
    logic [3:0]       r_run;

    logic             w_good;
    logic             w_wrap;
    logic [3:0]       w_run_inc;

    // Natural WIDTH-bit wrap makes max->0 a good step.
    assign w_good    = (q == WIDTH'(r_prev + C_ONE));
    assign w_wrap    = (r_prev == C_ONES) && (q == '0);
    assign w_run_inc = r_run + 4'd1;

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            r_state  <= ST_EMPTY;
            r_prev   <= '0;
            r_run    <= 4'd0;
            locked   <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= 8'd0;
            wrap_cnt <= 8'd0;
            expected <= C_ONE;
        end else begin
            err <= 1'b0;
            if (en) begin
                r_prev   <= q;
                expected <= WIDTH'(q + C_ONE);
                case (r_state)
                    ST_EMPTY: begin
                        r_run   <= 4'd0;
                        r_state <= ST_ACQUIRE;
                    end
                    ST_ACQUIRE: begin
                        if (w_good) begin
                            if (w_run_inc == C_LOCK_CNT) begin
                                r_run   <= 4'd0;
                                r_state <= ST_LOCKED;
                                locked  <= 1'b1;
                            end else begin
                                r_run <= w_run_inc;
                            end
                        end else begin
                            r_run <= 4'd0;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_good) begin
                            if (w_wrap) begin
                                wrap_cnt <= wrap_cnt + 8'd1;
                            end
                        end else begin
                            err    <= 1'b1;
                            locked <= 1'b0;
                            if (err_cnt != 8'hFF) begin
                                err_cnt <= err_cnt + 8'd1;
                            end
`ifdef COUNT_CHECK_RELOCK_EN
                            r_run   <= 4'd0;
                            r_state <= ST_ACQUIRE;
`else
                            r_state <= ST_FAULT;
`endif
                        end
                    end
                    ST_FAULT: begin
                        r_state <= ST_FAULT;
                    end
                    default: begin
                        r_state <= ST_EMPTY;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/count_seq_checker.md
# count_seq_checker

Receive-side checker for the free-running 4-bit counter output `q`.
- Samples the counter value on each qualified clock and confirms it advances by exactly +1 modulo 2^WIDTH.
- Declares lock after a run of good steps, flags every sequence break and keeps error and wrap statistics.
- Sits downstream of the counter in the same clock domain, as the self-check end for counter bring-up and board tests.

## Interface
Parameters:
- `WIDTH`, 4: width of the observed count.
- `LOCK_CNT`, 3: consecutive good steps needed to reach lock; legal range 1–15.

Ports:
- `clk`  in  1: system clock, rising edge.
- `rs`  in  1: reset; asynchronous, active-low.
- `en`  in  1: sample qualifier; `q` is examined only on cycles with `en`=1.
- `q`  in  WIDTH: counter value under test.
- `locked`  out  1: checker is in LOCKED.
- `err`  out  1: one-cycle pulse on a sequence break.
- `err_cnt`  out  8: break count, saturating at 255.
- `wrap_cnt`  out  8: count of observed max→0 wraps while locked; rolls over modulo 256.
- `expected`  out  WIDTH: next value the checker expects, equal to `prev`+1 modulo 2^WIDTH.

## Operation
Registers:
- `prev`: last sampled `q`.
- `run`: 4-bit good-step counter.
- `state`: one of EMPTY, ACQUIRE, LOCKED, FAULT.

A good step is `en`=1 and `q` == (`prev`+1) mod 2^WIDTH. All arithmetic is WIDTH-bit unsigned with natural wrap, so 15→0 is a good step for WIDTH=4.

Transitions, evaluated only when `en`=1. With `en`=0, every register holds.
- EMPTY: capture `prev`←`q`, `run`←0, go to ACQUIRE. No comparison is made.
- ACQUIRE, good step:
  - `run`←`run`+1.
  - If `run`+1 == LOCK_CNT, go to LOCKED and clear `run`.
- ACQUIRE, bad step: `run`←0 and stay in ACQUIRE. No `err` pulse and no `err_cnt` change; misses during acquisition are not errors.
- LOCKED, good step: stay in LOCKED. If `prev` is all-ones and `q`==0, increment `wrap_cnt`.
- LOCKED, bad step:
  - Pulse `err` and increment `err_cnt` (saturating).
  - Leave LOCKED as set by configuration.
- FAULT: absorbing. `prev` keeps tracking, nothing else changes, and `err` stays 0.
- `prev`←`q` on every qualified cycle in every state except FAULT, where it also updates. Re-acquisition therefore starts from the offending value.

Boundary conditions:
- Repeated value (`q`==`prev`): counts as a bad step.
- Backwards step: counts as a bad step.
- Reset mid-operation: all state clears immediately, independent of `clk`.
- `err_cnt` at 255 plus another break: `err` still pulses, `err_cnt` stays 255.
- `wrap_cnt` at 255 plus another wrap: rolls over to 0.

## Timing
- All outputs are registered.
- `locked`, `err`, the counters and `expected` reflect the sample taken on edge N starting right after edge N. Latency is 1 cycle from the sample edge.
- `err` is high for exactly one cycle per break, including when breaks occur on back-to-back cycles.
- Reset values while `rs`=0:
  - state = EMPTY, `prev` = 0, `run` = 0.
  - `locked` = 0, `err` = 0, `err_cnt` = 0, `wrap_cnt` = 0.
  - `expected` = 1.
- First qualified edge after `rs` deasserts is handled as EMPTY. With LOCK_CNT=3, `locked` rises after the 4th qualified sample.

## Configuration
- `COUNT_CHECK_RELOCK_EN` defined: a break in LOCKED goes to ACQUIRE with `run`=0. Lock is re-earned after LOCK_CNT further good steps.
- `COUNT_CHECK_RELOCK_EN` undefined: a break in LOCKED goes to FAULT. `locked` stays 0 until `rs` is asserted.

## Test plan
- Lock-up: release `rs` with `en`=1 and `q` = 0,1,2,3,… → `locked`=1 one cycle after the edge sampling `q`=3; `err_cnt`=0.
- Wrap: locked counter running 13,14,15,0,1 → `wrap_cnt` 0→1 after the edge sampling 0; no `err`; `expected`=1 after that edge.
- Break: locked sequence 5,6,9,10 → single `err` pulse after the edge sampling 9; `err_cnt`=1; `locked`=0.
  - With RELOCK_EN: relock after sampling 12.
  - Without RELOCK_EN: `locked` stays 0 through 20 further good steps.
- Qualifier: locked counter with `en` low for 3 cycles while `q` jumps arbitrarily, then `en`=1 with `q`=`expected` → no `err`, `locked` held.
- Saturation and stall: force 260 breaks (RELOCK_EN defined, relocking each time) → `err_cnt`=255. A repeated `q` (7,7) while locked counts as a break.
- Async reset: assert `rs`=0 mid-cycle while locked with nonzero counters → all outputs reach reset values before the next `clk` edge. Recovery repeats the lock-up case.
